// File: rtl/iomem_timer.sv
// iomem_timer: iomem-bus prescaled 32-bit timer/compare; capture input enabled by IOTIMER_CAPTURE_EN
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        cap_in,
  output logic        irq
);
  logic        ready_q, ready_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, count_q, count_d, cmp_q, cmp_d, capt_q, capt_d, rd_val;
  logic [2:0]  ctrl_q, ctrl_d, stat_q, stat_d, w1c;
  logic [15:0] presc_q, presc_d, pc_q, pc_d;
  logic [5:0]  off;
  logic        acc, wr, w_ctrl, w_presc, w_count, w_cmp, w_stat;
  logic        tick, hit, ovf, cap_evt, unused_addr;

  function automatic logic [31:0] bw(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  assign unused_addr = ^iomem_addr[1:0];
  assign off     = iomem_addr[7:2];
  assign acc     = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8] && !ready_q;
  assign wr      = acc && |iomem_wstrb;
  assign w_ctrl  = wr && off == 6'h00 && iomem_wstrb[0];
  assign w_presc = wr && off == 6'h01;
  assign w_count = wr && off == 6'h02;
  assign w_cmp   = wr && off == 6'h03;
  assign w_stat  = wr && off == 6'h04 && iomem_wstrb[0];

`ifdef IOTIMER_CAPTURE_EN
  logic [2:0] sync_q, sync_d;
  // two synchronizer stages plus one history stage for rising-edge detection
  always_comb sync_d = {sync_q[1:0], cap_in};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync_q <= '0;
    else sync_q <= sync_d;
  assign cap_evt = sync_q[1] && !sync_q[2];
`else
  logic unused_cap;
  assign unused_cap = cap_in;
  assign cap_evt = 1'b0;
`endif

  // timer datapath: prescaler tick, compare/overflow, software writes win over hardware updates
  always_comb begin
    tick    = ctrl_q[0] && pc_q == presc_q;
    hit     = tick && count_q == cmp_q;
    ovf     = tick && !hit && &count_q;
    pc_d    = (!ctrl_q[0] || tick || w_ctrl || w_presc || w_count) ? 16'd0 : pc_q + 16'd1;
    ctrl_d  = w_ctrl ? iomem_wdata[2:0] : (hit && !ctrl_q[1]) ? {ctrl_q[2:1], 1'b0} : ctrl_q;
    presc_d = w_presc ? {iomem_wstrb[1] ? iomem_wdata[15:8] : presc_q[15:8],
                         iomem_wstrb[0] ? iomem_wdata[7:0]  : presc_q[7:0]} : presc_q;
    count_d = w_count ? bw(count_q, iomem_wdata, iomem_wstrb) :
              hit     ? (ctrl_q[1] ? 32'd0 : count_q) :
              tick    ? count_q + 32'd1 : count_q;
    cmp_d   = w_cmp ? bw(cmp_q, iomem_wdata, iomem_wstrb) : cmp_q;
    w1c     = w_stat ? iomem_wdata[2:0] : 3'd0;
    stat_d  = (stat_q & ~w1c) | {cap_evt, ovf, hit};
    capt_d  = cap_evt ? count_q : capt_q;
    irq_d   = ctrl_q[2] && stat_q[0];
  end

  // read mux sampled on the accept edge; rdata is zero whenever ready is low
  always_comb begin
    rd_val  = off == 6'h00 ? {29'd0, ctrl_q} :
              off == 6'h01 ? {16'd0, presc_q} :
              off == 6'h02 ? count_q :
              off == 6'h03 ? cmp_q :
              off == 6'h04 ? {29'd0, stat_q} :
              off == 6'h05 ? capt_q : 32'd0;
    rdata_d = acc ? rd_val : 32'd0;
    ready_d = acc;
  end

  // state registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      ctrl_q  <= '0;
      presc_q <= RESET_PRESCALE;
      count_q <= '0;
      cmp_q   <= '0;
      stat_q  <= '0;
      capt_q  <= '0;
      pc_q    <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      stat_q  <= stat_d;
      capt_q  <= capt_d;
      pc_q    <= pc_d;
    end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: table vectors, directed timing sequences and a randomized tick-level reference model
module tb_iomem_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [15:0] RP   = 16'd0;

  logic        clk = 1'b0, resetn = 1'b0, valid = 1'b0, cap_in = 1'b0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        ready, irq;
  logic [31:0] rdata;
  int          cyc = 0, nvec = 0, nerr = 0;
  int          last_e;
  logic [31:0] last_r;
  logic        last_irq_a, last_irq_b;

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  iomem_timer #(.BASE_ADDR(BASE), .RESET_PRESCALE(RP)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata),
    .iomem_rdata(rdata), .cap_in(cap_in), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    nvec++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  task automatic bus(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; addr = BASE | {24'd0, off}; wstrb = s; wdata = d;
    @(posedge clk); #1;
    last_e = cyc; last_r = rdata; last_irq_a = irq;
    chk("ready_pulse", {31'd0, ready}, 32'd1);
    @(negedge clk);
    valid = 1'b0; wstrb = 4'd0;
    @(posedge clk); #1;
    last_irq_b = irq;
    chk("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    bus(off, s, d);
  endtask

  task automatic rd(input logic [7:0] off, input string n, input logic [31:0] x);
    bus(off, 4'd0, 32'd0);
    chk(n, last_r, x);
  endtask

  task automatic wait_until(input int t);
    if (cyc >= t) chk("wait_late", cyc, t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic add(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d, input logic [31:0] x);
    vec_t v;
    v.off = off; v.s = s; v.d = d; v.exp = x;
    tbl.push_back(v);
  endtask

  // state after n cycles of counting, stepping tick by tick through the timer rules
  function automatic void model(input int p, input logic [31:0] c0, input logic [31:0] cmp, input logic au,
                                input int n, output logic [31:0] cnt, output logic m, output logic o,
                                output logic en);
    cnt = c0; m = 1'b0; o = 1'b0; en = 1'b1;
    for (int k = 1; k * (p + 1) <= n && en; k++) begin
      if (cnt == cmp) begin
        m = 1'b1;
        if (au) cnt = 32'd0;
        else en = 1'b0;
      end else begin
        if (cnt == 32'hFFFF_FFFF) o = 1'b1;
        cnt = cnt + 32'd1;
      end
    end
  endfunction

  task automatic clean();
    wr(8'h00, 4'h1, 32'd0);
    wr(8'h10, 4'h1, 32'd7);
  endtask

  initial begin
    int e, e1, p, w, n;
    logic [31:0] cmp, c0, mc;
    logic au, ie, mm, mo, me;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    add(8'h00, 4'h0, 0, 32'd0);
    add(8'h04, 4'h0, 0, {16'd0, RP});
    add(8'h08, 4'h0, 0, 32'd0);
    add(8'h0C, 4'h0, 0, 32'd0);
    add(8'h10, 4'h0, 0, 32'd0);
    add(8'h14, 4'h0, 0, 32'd0);
    add(8'h18, 4'h0, 0, 32'd0);
    add(8'h0C, 4'hF, 32'd0, 0);
    add(8'h0C, 4'h4, 32'h12AB_3456, 0);
    add(8'h0C, 4'h0, 0, 32'h00AB_0000);
    add(8'h20, 4'hF, 32'hFFFF_FFFF, 0);
    add(8'h20, 4'h0, 0, 32'd0);
    add(8'h00, 4'hF, 32'hFFFF_FFF8, 0);
    add(8'h00, 4'h0, 0, 32'd0);
    add(8'h00, 4'hE, 32'h0000_0007, 0);
    add(8'h00, 4'h0, 0, 32'd0);
    add(8'h00, 4'h1, 32'h0000_0006, 0);
    add(8'h00, 4'h0, 0, 32'd6);
    add(8'h00, 4'h1, 32'd0, 0);
    add(8'h04, 4'hF, 32'hFFFF_1234, 0);
    add(8'h04, 4'h0, 0, 32'h0000_1234);
    add(8'h04, 4'h2, 32'h0000_5600, 0);
    add(8'h04, 4'h0, 0, 32'h0000_5634);
    add(8'h04, 4'h3, 32'd0, 0);
    add(8'h08, 4'h9, 32'h1234_5678, 0);
    add(8'h08, 4'h0, 0, 32'h1200_0078);
    add(8'h08, 4'hF, 32'd0, 0);
    add(8'h14, 4'hF, 32'hFFFF_FFFF, 0);
    add(8'h14, 4'h0, 0, 32'd0);
    add(8'h10, 4'hF, 32'd7, 0);
    add(8'h10, 4'h0, 0, 32'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].s == 4'd0) rd(tbl[i].off, $sformatf("tbl%0d_off%h", i, tbl[i].off), tbl[i].exp);
      else wr(tbl[i].off, tbl[i].s, tbl[i].d);
    end

    @(negedge clk);
    valid = 1'b1; addr = BASE + 32'h100; wstrb = 4'hF; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("outside_no_ready", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    valid = 1'b0; wstrb = 4'd0;
    rd(8'h00, "outside_ctrl", 32'd0);

    clean();
    wr(8'h08, 4'hF, 32'd0);
    wr(8'h04, 4'h3, 32'd3);
    wr(8'h0C, 4'hF, 32'd5);
    wr(8'h00, 4'h1, 32'd7);
    e = last_e;
    wait_until(e + 24);
    chk("per_irq_pre", {31'd0, irq}, 32'd0);
    rd(8'h10, "per_match", 32'd1);
    chk("per_irq", {31'd0, last_irq_a}, 32'd1);
    rd(8'h08, "per_wrap", 32'd0);
    wr(8'h10, 4'h1, 32'd1);
    wait_until(e + 47);
    rd(8'h10, "per_match2_pre", 32'd0);
    rd(8'h10, "per_match2", 32'd1);

    clean();
    wr(8'h08, 4'hF, 32'd0);
    wr(8'h04, 4'h3, 32'd0);
    wr(8'h0C, 4'hF, 32'd2);
    wr(8'h00, 4'h1, 32'd5);
    repeat (8) @(posedge clk);
    rd(8'h08, "os_count", 32'd2);
    rd(8'h00, "os_ctrl", 32'd4);
    rd(8'h10, "os_status", 32'd1);
    chk("os_irq", {31'd0, last_irq_a}, 32'd1);
    wr(8'h10, 4'h1, 32'd1);
    chk("os_irq_hold", {31'd0, last_irq_a}, 32'd1);
    chk("os_irq_fall", {31'd0, last_irq_b}, 32'd0);
    rd(8'h10, "os_cleared", 32'd0);

    clean();
    wr(8'h04, 4'h3, 32'd0);
    wr(8'h0C, 4'hF, 32'd1);
    wr(8'h08, 4'hF, 32'hFFFF_FFFE);
    wr(8'h00, 4'h1, 32'd1);
    e = last_e;
    wait_until(e + 2);
    rd(8'h10, "ovf_status", 32'd2);
    rd(8'h08, "ovf_count", 32'd1);
    rd(8'h10, "ovf_match", 32'd3);
    rd(8'h00, "ovf_ctrl", 32'd0);

    clean();
    wr(8'h08, 4'hF, 32'h0000_55AA);
    @(negedge clk);
    cap_in = 1'b1;
    e1 = cyc + 1;
    wait_until(e1 + 1);
    rd(8'h14, "cap_early", 32'd0);
`ifdef IOTIMER_CAPTURE_EN
    rd(8'h14, "cap_value", 32'h0000_55AA);
    rd(8'h10, "cap_flag", 32'd4);
`else
    rd(8'h14, "cap_value", 32'd0);
    rd(8'h10, "cap_flag", 32'd0);
`endif
    cap_in = 1'b0;
    repeat (4) @(posedge clk);

    for (int it = 0; it < 25; it++) begin
      p   = int'($urandom_range(0, 3));
      cmp = 32'($urandom_range(0, 6));
      c0  = $urandom_range(0, 1) ? 32'($urandom_range(0, 4)) : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      au  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      w   = int'($urandom_range(0, 30));
      clean();
      wr(8'h04, 4'h3, p);
      wr(8'h0C, 4'hF, cmp);
      wr(8'h08, 4'hF, c0);
      wr(8'h00, 4'h1, {29'd0, ie, au, 1'b1});
      e = last_e;
      repeat (w) @(posedge clk);
      bus(8'h08, 4'd0, 32'd0);
      n = last_e - 1 - e;
      model(p, c0, cmp, au, n, mc, mm, mo, me);
      chk($sformatf("rnd%0d_count", it), last_r, mc);
      bus(8'h10, 4'd0, 32'd0);
      n = last_e - 1 - e;
      model(p, c0, cmp, au, n, mc, mm, mo, me);
      chk($sformatf("rnd%0d_status", it), last_r, {30'd0, mo, mm});
      bus(8'h00, 4'd0, 32'd0);
      n = last_e - 1 - e;
      model(p, c0, cmp, au, n, mc, mm, mo, me);
      chk($sformatf("rnd%0d_ctrl", it), last_r, {29'd0, ie, au, me});
      chk($sformatf("rnd%0d_irq", it), {31'd0, last_irq_a}, {31'd0, ie && mm});
    end

    wr(8'h04, 4'h3, 32'd2);
    wr(8'h08, 4'hF, 32'h0000_1234);
    wr(8'h00, 4'h1, 32'd1);
    @(negedge clk);
    valid = 1'b1; addr = BASE | 32'h8; wstrb = 4'd0;
    @(posedge clk); #1;
    chk("arst_ready_before", {31'd0, ready}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    valid = 1'b1; addr = BASE | 32'h8; wstrb = 4'hF; wdata = 32'hDEAD_BEEF;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("arst_write_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    valid = 1'b0; wstrb = 4'd0;
    resetn = 1'b1;
    rd(8'h08, "arst_count", 32'd0);
    rd(8'h00, "arst_ctrl", 32'd0);
    rd(8'h04, "arst_presc", {16'd0, RP});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
